// File: rtl/process_scheduler_pkg.sv
// Shared types and helpers for the process scheduler: FSM state encoding,
// default sizing constants and a one-hot decode helper.
package process_scheduler_pkg;

  typedef enum logic [1:0] {IDLE, INIT, RUN, HALT} state_e;

  localparam int DEFAULT_PROCESSES  = 4;
  localparam int DEFAULT_STEP_WIDTH = 32;
  // Upper bound on process count; callers size-cast the result down.
  localparam int MAX_PROCESSES      = 256;

  function automatic logic [MAX_PROCESSES-1:0] onehot(input int unsigned index);
    return MAX_PROCESSES'(1) << index;
  endfunction

endpackage

// File: rtl/process_scheduler_next_slot.sv
// Slot sequencing for one step. With PROCESS_SCHEDULER_SKIP_STOPPED_EN defined,
// stopped processes are skipped; otherwise every slot is visited in order.
module process_scheduler_next_slot
  import process_scheduler_pkg::*;
#(
  parameter int PROCESSES = DEFAULT_PROCESSES,
  parameter int PID_WIDTH = (PROCESSES > 1) ? $clog2(PROCESSES) : 1
) (
  input  logic [PID_WIDTH-1:0] slot,
  input  logic [PROCESSES-1:0] process_stop,
  output logic [PID_WIDTH-1:0] next_slot,
  output logic                 last,
  output logic [PID_WIDTH-1:0] first_slot,
  output logic                 none_live
);

`ifdef PROCESS_SCHEDULER_SKIP_STOPPED_EN
  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    next_slot  = slot;
    last       = 1'b1;
    first_slot = '0;
    none_live  = 1'b1;
    for (int i = PROCESSES - 1; i >= 0; i--) begin
      if (!process_stop[i]) begin
        first_slot = PID_WIDTH'(i);
        none_live  = 1'b0;
        if (i > int'(slot)) begin
          next_slot = PID_WIDTH'(i);
          last      = 1'b0;
        end
      end
    end
  end
`else
  logic unused_stop;
  assign unused_stop = ^process_stop;
  assign next_slot   = slot + 1'b1;
  assign last        = (slot == PID_WIDTH'(PROCESSES - 1));
  assign first_slot  = '0;
  assign none_live   = 1'b0;
`endif

endmodule

// File: rtl/process_scheduler.sv
// Process scheduler: one init cycle, then steps of one execute slot per process.
// Optional macro PROCESS_SCHEDULER_SKIP_STOPPED_EN skips stopped processes.
module process_scheduler
  import process_scheduler_pkg::*;
#(
  parameter int PROCESSES  = DEFAULT_PROCESSES,
  parameter int STEP_WIDTH = DEFAULT_STEP_WIDTH,
  parameter int PID_WIDTH  = (PROCESSES > 1) ? $clog2(PROCESSES) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [STEP_WIDTH-1:0] maxSteps,
  input  logic [PROCESSES-1:0]  processStop,
  output logic                  initialise,
  output logic [PROCESSES-1:0]  processEnable,
  output logic [PID_WIDTH-1:0]  processCurrent,
  output logic [STEP_WIDTH-1:0] step,
  output logic                  stepDone,
  output logic                  running,
  output logic                  stopped,
  output logic                  timeout
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_INIT = INIT;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_HALT = HALT;

  logic [1:0]            state;
  logic [PID_WIDTH-1:0]  slot, next_slot, first_slot;
  logic                  last, none_live;
  logic [STEP_WIDTH-1:0] max_steps_q, step_inc;

  process_scheduler_next_slot #(.PROCESSES(PROCESSES), .PID_WIDTH(PID_WIDTH)) u_next_slot (
    .slot         (slot),
    .process_stop (processStop),
    .next_slot    (next_slot),
    .last         (last),
    .first_slot   (first_slot),
    .none_live    (none_live)
  );

  assign step_inc       = step + 1'b1;
  assign initialise     = (state == ST_INIT);
  assign running        = (state == ST_INIT) || (state == ST_RUN);
  assign processEnable  = (state == ST_RUN) ? PROCESSES'(onehot(32'(slot))) : '0;
  assign processCurrent = (state == ST_RUN) ? slot : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      slot        <= '0;
      max_steps_q <= '0;
      step        <= '0;
      stepDone    <= 1'b0;
      stopped     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      stepDone <= 1'b0;
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            max_steps_q <= maxSteps;
            step        <= '0;
            stopped     <= 1'b0;
            timeout     <= 1'b0;
            state       <= ST_INIT;
          end
        end
        ST_INIT: begin
          if (max_steps_q == '0) begin
            timeout <= 1'b1;
            state   <= ST_HALT;
          end else if (none_live) begin
            // Zero-slot step: everything already stopped before the first slot.
            step     <= step_inc;
            stepDone <= 1'b1;
            stopped  <= 1'b1;
            state    <= ST_HALT;
          end else begin
            slot  <= first_slot;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (last) begin
            step     <= step_inc;
            stepDone <= 1'b1;
            if (&processStop) begin
              stopped <= 1'b1;
              state   <= ST_HALT;
            end else if (step_inc == max_steps_q) begin
              timeout <= 1'b1;
              state   <= ST_HALT;
            end else begin
              slot <= first_slot;
            end
          end else begin
            slot <= next_slot;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
